gf_mod_reduce_seq: RTL and testbench
====================================

Name: gf_mod_reduce_seq

Overview:
- Sequential GF(2^M) modular reduction stage, directly downstream of the combinational carry-less multiplier.
- Consumes the raw (2M-1)-bit polynomial product and reduces it modulo a run-time-programmable irreducible polynomial, one bit per cycle, MSB first.
- Returns the M-bit field element, so the multiplier plus this block form a complete GF(2^M) multiply.
- The field polynomial is a port because the Goppa/Niederreiter datapath uses different fields.

Parameters:
- M, 8, field degree (M >= 2). Product width is 2M-1; result width is M.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset; takes priority over every other input.
- start_in  input  1  request; sampled only while ready_out=1.
- prod_in  input  2M-1  carry-less product; bit i = coefficient of x^i.
- poly_in  input  M+1  irreducible polynomial. Bit M is treated as 1 regardless of its value. Sampled with start_in.
- ready_out  output  1  high while IDLE; block can accept start_in.
- done_out  output  1  one-cycle pulse; res_out is valid and new.
- res_out  output  M  reduced result, prod mod poly; held until the next done_out.

Behaviour:
- Internal state:
  - acc, 2M-1 bits.
  - poly_r, M bits (low M bits of poly_in).
  - cnt, ceil(log2(M)) bits.
  - state in {IDLE, REDUCE}.
- Reset (sampled rst=1 at an edge):
  - state=IDLE, acc=0, poly_r=0, cnt=0.
  - res_out=0, done_out=0, ready_out=1.
- ready_out = (state==IDLE), decoded from registered state.
- IDLE:
  - On an edge with start_in=1: acc<=prod_in, poly_r<=poly_in[M-1:0], cnt<=M-2, state<=REDUCE.
  - done_out<=0 on that edge.
  - start_in=0 leaves all state unchanged.
- REDUCE, per edge, with k = M+cnt (k runs 2M-2 down to M):
  - If acc[k]=1: acc[k]<=0 and acc[k-1:k-M] ^= poly_r.
  - Otherwise acc is unchanged.
  - Bits above k are already zero and are untouched.
- REDUCE exit:
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0 (final step): res_out <= post-step acc[M-1:0], done_out<=1, state<=IDLE.
- Latency:
  - start accepted at edge E0; reduction steps at E1..E(M-1).
  - done_out high during the cycle after E(M-1).
  - Fixed M-1 reduction cycles regardless of data. Products < 2^M still take M-1 cycles and pass through unchanged.
- done_out is high for exactly one cycle and clears on the next edge unless another completion occurs (impossible, since minimum spacing is M cycles).
- Back-to-back: start_in may be asserted in the done_out cycle (ready_out=1). Throughput is one result per M cycles.
- start_in while in REDUCE is ignored; prod_in and poly_in changes during REDUCE have no effect.
- rst in REDUCE aborts the operation: no done_out, res_out=0, IDLE on the next cycle.
- rst and start_in in the same cycle: reset wins, start is dropped.
- poly_in is not checked for irreducibility. Result is always prod mod (x^M + poly_r) for any poly_r.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: hold rst 2 cycles with start_in=1, prod_in=0x3F7E -> ready_out=1, done_out=0, res_out=0x00; no operation starts.
- AES field: M=8, poly_in=0x11B, prod_in=0x3F7E (0x53·0xCA), start 1 cycle -> done_out pulses exactly 7 cycles after the accept edge, res_out=0x01; ready_out low during those 7 cycles.
- Back-to-back: start prod_in=0x2B79, poly 0x11B; re-assert start in the done cycle with prod_in=0x3F7E -> res_out=0xC1 at first done, 0x01 at second done, exactly 8 cycles apart.
- Alternate polynomial and pass-through:
  - poly_in=0x11D, prod_in=0x0100 -> res_out=0x1D.
  - prod_in=0x00A5 -> res_out=0xA5, same 7-cycle latency.
- Busy protection: during REDUCE, toggle start_in and change prod_in and poly_in to random values -> result unaffected (0x3F7E/0x11B still gives 0x01); exactly one done_out pulse.
- Mid-op reset: rst for one cycle at the 3rd REDUCE cycle -> next cycle ready_out=1, res_out=0, no done_out. A following start with 0x2B79/0x11B gives 0xC1.

Source files
------------

// File: rtl/gf_mod_reduce_seq.sv
// Sequential GF(2^M) reduction of a (2M-1)-bit carry-less product modulo x^M + poly, one bit per cycle MSB first.
// Latency: M-1 reduction cycles after the accept edge; done_out is high during the cycle after the last step.
// Backpressure: ready_out is high only in IDLE; start_in is ignored while busy (one result per M cycles).
//
// Ports:
//   clk       - clock, all state updates on rising edge
//   rst       - synchronous active-high reset, overrides every other input
//   start_in  - request, sampled only while ready_out=1
//   prod_in   - (2M-1)-bit carry-less product, bit i = coefficient of x^i
//   poly_in   - (M+1)-bit field polynomial; bit M is implied 1, only [M-1:0] is kept
//   ready_out - block is idle and can accept start_in
//   done_out  - one-cycle pulse, res_out is new
//   res_out   - M-bit reduced result, held until the next done_out
module gf_mod_reduce_seq #(
  parameter int M = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_in,
  input  logic [2*M-2:0] prod_in,
  input  logic [M:0]     poly_in,
  output logic           ready_out,
  output logic           done_out,
  output logic [M-1:0]   res_out
);

  localparam int PW    = 2 * M - 1;
  localparam int CNT_W = (M > 2) ? $clog2(M) : 1;

  // Single bit at x^M; shifted by cnt it selects the bit being eliminated this step.
  localparam logic [PW-1:0] TOP_ONE = PW'(1) << M;

  typedef enum logic {
    IDLE   = 1'b0,
    REDUCE = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [M-1:0]       poly_q, poly_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [M-1:0]       res_q, res_d;
  logic               done_q, done_d;

  // Full modulus x^M + poly_r aligned so its leading term sits at bit k = M + cnt.
  // XORing it in clears acc[k] and folds poly_r into acc[k-1:k-M] in one go.
  logic [PW-1:0]      red_mask;
  logic               top_hit;

  always_comb begin
    red_mask = PW'({1'b1, poly_q}) << cnt_q;
    top_hit  = |(acc_q & (TOP_ONE << cnt_q));
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    poly_d  = poly_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_in) begin
          acc_d   = prod_in;
          poly_d  = poly_in[M-1:0];
          cnt_d   = CNT_W'(M - 2);
          state_d = REDUCE;
        end
      end

      REDUCE: begin
        if (top_hit) begin
          acc_d = acc_q ^ red_mask;
        end
        if (cnt_q == '0) begin
          // Last step: bits M and above are now all zero.
          res_d   = acc_d[M-1:0];
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      poly_q  <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      poly_q  <= poly_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  assign ready_out = (state_q == IDLE);
  assign done_out  = done_q;
  assign res_out   = res_q;

endmodule

// File: tb/tb_gf_mod_reduce_seq.sv
module tb_gf_mod_reduce_seq;

  localparam int M  = 8;
  localparam int PW = 2 * M - 1;

  logic           clk;
  logic           rst;
  logic           start_in;
  logic [PW-1:0]  prod_in;
  logic [M:0]     poly_in;
  logic           ready_out;
  logic           done_out;
  logic [M-1:0]   res_out;

  int pass_cnt;
  int total_cnt;

  gf_mod_reduce_seq #(.M(M)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_in  (start_in),
    .prod_in   (prod_in),
    .poly_in   (poly_in),
    .ready_out (ready_out),
    .done_out  (done_out),
    .res_out   (res_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] prod;
    logic [M:0]    poly;
    logic [M-1:0]  exp_res;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Advance one edge; inputs are then changed and outputs read 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for done_out with a bound; returns cycles waited (0 on timeout).
  task automatic wait_done(input string name, input bit chk_busy, output int cycles);
    int n;
    n = 0;
    cycles = 0;
    while (n < 20) begin
      step();
      n++;
      if (done_out) begin
        cycles = n;
        break;
      end
      if (chk_busy) check({name, "_ready_low"}, 32'(ready_out), 32'd0);
    end
    if (cycles == 0) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_op(input string name, input logic [PW-1:0] p, input logic [M:0] q,
                        input logic [M-1:0] exp_res);
    int cyc;
    check({name, "_ready_before"}, 32'(ready_out), 32'd1);
    start_in = 1'b1;
    prod_in  = p;
    poly_in  = q;
    step();
    start_in = 1'b0;
    wait_done(name, 1'b0, cyc);
    check({name, "_latency"}, 32'(cyc), 32'd7);
    check({name, "_res"}, 32'(res_out), 32'(exp_res));
    check({name, "_ready_done"}, 32'(ready_out), 32'd1);
    step();
    check({name, "_done_one_cycle"}, 32'(done_out), 32'd0);
    check({name, "_res_held"}, 32'(res_out), 32'(exp_res));
  endtask

  vec_t vecs[6];

  initial begin
    int cyc;
    int pulses;
    logic [M-1:0] cap;

    pass_cnt  = 0;
    total_cnt = 0;

    vecs[0] = '{prod: 15'h3F7E, poly: 9'h11B, exp_res: 8'h01};
    vecs[1] = '{prod: 15'h2B79, poly: 9'h11B, exp_res: 8'hC1};
    vecs[2] = '{prod: 15'h0100, poly: 9'h11D, exp_res: 8'h1D};
    vecs[3] = '{prod: 15'h00A5, poly: 9'h11D, exp_res: 8'hA5};
    vecs[4] = '{prod: 15'h3F7E, poly: 9'h01B, exp_res: 8'h01}; // bit M of poly_in ignored
    vecs[5] = '{prod: 15'h0000, poly: 9'h11B, exp_res: 8'h00};

    // Reset with start held high: nothing may start.
    rst      = 1'b1;
    start_in = 1'b1;
    prod_in  = 15'h3F7E;
    poly_in  = 9'h11B;
    step();
    step();
    check("rst_ready", 32'(ready_out), 32'd1);
    check("rst_done",  32'(done_out),  32'd0);
    check("rst_res",   32'(res_out),   32'h00);
    rst      = 1'b0;
    start_in = 1'b0;
    step();
    check("rst_no_op_ready", 32'(ready_out), 32'd1);

    // Busy flag during a full operation, then the vector table.
    start_in = 1'b1;
    prod_in  = 15'h3F7E;
    poly_in  = 9'h11B;
    step();
    start_in = 1'b0;
    wait_done("aes_busy", 1'b1, cyc);
    check("aes_busy_latency", 32'(cyc), 32'd7);
    check("aes_busy_res", 32'(res_out), 32'h01);
    step();

    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].prod, vecs[i].poly, vecs[i].exp_res);
    end

    // Back-to-back: second start asserted in the done cycle.
    start_in = 1'b1;
    prod_in  = 15'h2B79;
    poly_in  = 9'h11B;
    step();
    start_in = 1'b0;
    wait_done("b2b_first", 1'b0, cyc);
    check("b2b_first_res", 32'(res_out), 32'hC1);
    start_in = 1'b1;
    prod_in  = 15'h3F7E;
    poly_in  = 9'h11B;
    step();
    start_in = 1'b0;
    cyc = 1;
    if (!done_out) begin
      wait_done("b2b_second", 1'b0, cyc);
      cyc = cyc + 1;
    end
    check("b2b_spacing", 32'(cyc), 32'd8);
    check("b2b_second_res", 32'(res_out), 32'h01);
    step();

    // Busy protection: junk on inputs during REDUCE.
    start_in = 1'b1;
    prod_in  = 15'h3F7E;
    poly_in  = 9'h11B;
    step();
    pulses = 0;
    cap    = '0;
    for (int i = 0; i < 7; i++) begin
      start_in = ~start_in;
      prod_in  = PW'($urandom);
      poly_in  = 9'($urandom);
      step();
      if (done_out) begin
        pulses++;
        cap = res_out;
      end
    end
    start_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (done_out) pulses++;
    end
    check("busy_pulses", 32'(pulses), 32'd1);
    check("busy_res", 32'(cap), 32'h01);

    // Mid-operation reset in the third REDUCE cycle.
    start_in = 1'b1;
    prod_in  = 15'h3F7E;
    poly_in  = 9'h11B;
    step();
    start_in = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_ready", 32'(ready_out), 32'd1);
    check("midrst_res",   32'(res_out),   32'h00);
    check("midrst_done",  32'(done_out),  32'd0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done_out) pulses++;
    end
    check("midrst_no_done", 32'(pulses), 32'd0);
    run_op("after_rst", 15'h2B79, 9'h11B, 8'hC1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
